// File: rtl/line_pkg.sv
// Shared character constants and helpers for the line release buffer.
package line_pkg;

  localparam logic [7:0] CHAR_LF = 8'h0a;
  localparam logic [7:0] CHAR_CR = 8'h0d;

  // A byte that closes the current line and releases it to the transmitter.
  function automatic logic is_terminator(input logic [7:0] b);
    return (b == CHAR_LF) || (b == CHAR_CR);
  endfunction

endpackage

// File: rtl/sfifo.sv
// Synchronous byte FIFO with an extra pointer bit for full/empty detection.
// The head word is presented combinationally so the transmitter sees it as
// soon as a line is released. A write that arrives while the FIFO is full
// is taken when the same cycle also pops the head.
module sfifo #(
  parameter int BW     = 8,
  parameter int LGFLEN = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_wr,
  input  logic [BW-1:0]     i_data,
  input  logic              i_rd,
  output logic [BW-1:0]     o_data,
  output logic [LGFLEN:0]   o_fill,
  output logic              o_full
);

  localparam logic [LGFLEN:0] FULL_LVL = (LGFLEN+1)'(1 << LGFLEN);

  logic [BW-1:0]   mem [1 << LGFLEN];
  logic [LGFLEN:0] wr_ptr;
  logic [LGFLEN:0] rd_ptr;
  logic            empty;
  logic            do_wr;
  logic            do_rd;

  assign o_fill = wr_ptr - rd_ptr;
  assign o_full = (o_fill == FULL_LVL);
  assign empty  = (o_fill == '0);
  assign do_rd  = i_rd && !empty;
  assign do_wr  = i_wr && (!o_full || do_rd);
  assign o_data = mem[rd_ptr[LGFLEN-1:0]];

  // Pointer advance; reset empties the FIFO without touching storage.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents are don't-care until a pointer covers them.
  always_ff @(posedge i_clk) begin
    if (do_wr) mem[wr_ptr[LGFLEN-1:0]] <= i_data;
  end

endmodule

// File: rtl/line_release_buffer.sv
// Line release buffer between rxuart and txuart. Received bytes are stored
// but held back from the transmitter until their line is released by a
// terminator, by reaching MAX_LINE bytes, or by an idle timeout.
// release_cnt counts stored bytes that belong to released lines; open_len
// counts bytes of the line still being collected. Their sum is the FIFO fill.
module line_release_buffer
  import line_pkg::*;
#(
  parameter int LGFLEN            = 8,
  parameter int MAX_LINE          = 80,
  parameter int TIMEOUT           = 0,
  parameter bit OPT_CRLF_COLLAPSE = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_rx_stb,
  input  logic [7:0]        i_rx_data,
  output logic              o_tx_stb,
  output logic [7:0]        o_tx_data,
  input  logic              i_tx_busy,
  output logic [LGFLEN:0]   o_fill,
  output logic [LGFLEN:0]   o_open_len,
  output logic              o_overflow
);

  localparam int              TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]   IDLE_LOAD = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
  localparam logic [LGFLEN:0] MAX_LEN   = (LGFLEN+1)'(MAX_LINE);

  logic [LGFLEN:0] fill;
  logic [LGFLEN:0] release_cnt;
  logic [LGFLEN:0] release_nxt;
  logic [LGFLEN:0] open_len;
  logic [LGFLEN:0] open_nxt;
  logic [TW-1:0]   idle_cnt;
  logic            full;
  logic            last_was_cr;
  logic            drop_lf;
  logic            rx_take;
  logic            wr_en;
  logic            rd_en;
  logic            tmo_hit;
  logic            force_rel;

  assign rd_en     = o_tx_stb && !i_tx_busy;
  assign drop_lf   = OPT_CRLF_COLLAPSE && last_was_cr && (i_rx_data == CHAR_LF);
  assign rx_take   = i_rx_stb && !drop_lf;
  assign wr_en     = rx_take && (!full || rd_en);
  assign tmo_hit   = (TIMEOUT > 0) && !i_rx_stb && (open_len != '0) && (idle_cnt == '0);
  // Safety net: a full FIFO holding only an open line would never drain.
  assign force_rel = full && (open_len == fill) && (open_len != '0);

  assign o_fill     = fill;
  assign o_open_len = open_len;

  sfifo #(
    .BW     (8),
    .LGFLEN (LGFLEN)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_wr    (wr_en),
    .i_data  (i_rx_data),
    .i_rd    (rd_en),
    .o_data  (o_tx_data),
    .o_fill  (fill),
    .o_full  (full)
  );

  // Next-state of the line counters: release on write/timeout, minus a pop.
  always_comb begin
    release_nxt = release_cnt;
    open_nxt    = open_len;
    if (wr_en) begin
      if (is_terminator(i_rx_data) || ((open_len + 1'b1) == MAX_LEN)) begin
        release_nxt = release_cnt + open_len + 1'b1;
        open_nxt    = '0;
      end else begin
        open_nxt = open_len + 1'b1;
      end
    end else if (tmo_hit || force_rel) begin
      release_nxt = release_cnt + open_len;
      open_nxt    = '0;
    end
    if (rd_en) release_nxt = release_nxt - 1'b1;
  end

  // Registered counters, tx strobe, overflow pulse, CR tracking, idle timer.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      release_cnt <= '0;
      open_len    <= '0;
      o_tx_stb    <= 1'b0;
      o_overflow  <= 1'b0;
      last_was_cr <= 1'b0;
      idle_cnt    <= '0;
    end else begin
      release_cnt <= release_nxt;
      open_len    <= open_nxt;
      o_tx_stb    <= (release_nxt != '0);
      o_overflow  <= rx_take && full && !rd_en;
      if (i_rx_stb) begin
        last_was_cr <= (i_rx_data == CHAR_CR);
        idle_cnt    <= IDLE_LOAD;
      end else if ((open_len != '0) && (idle_cnt != '0)) begin
        idle_cnt <= idle_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_line_release_buffer.sv
// Directed bench for line_release_buffer. Four instances share the stimulus
// and differ only in parameters; each scenario checks the relevant instance.
module tb_line_release_buffer;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_rx_stb;
  logic [7:0] i_rx_data;
  logic       i_tx_busy;

  logic       d_stb, m_stb, t_stb, s_stb;
  logic [7:0] d_data, m_data, t_data, s_data;
  logic [8:0] d_fill, d_open, m_fill, m_open, t_fill, t_open;
  logic [4:0] s_fill, s_open;
  logic       d_ovf, m_ovf, t_ovf, s_ovf;

  logic [7:0] q_d[$];
  logic [7:0] q_m[$];
  logic [7:0] q_t[$];
  logic [7:0] q_s[$];

  int total = 0;
  int bad   = 0;

  always #5 i_clk = ~i_clk;

  line_release_buffer #(.LGFLEN(8), .MAX_LINE(80), .TIMEOUT(0), .OPT_CRLF_COLLAPSE(1'b1)) u_dflt (
    .i_clk(i_clk), .i_reset(i_reset), .i_rx_stb(i_rx_stb), .i_rx_data(i_rx_data),
    .o_tx_stb(d_stb), .o_tx_data(d_data), .i_tx_busy(i_tx_busy),
    .o_fill(d_fill), .o_open_len(d_open), .o_overflow(d_ovf));

  line_release_buffer #(.LGFLEN(8), .MAX_LINE(4), .TIMEOUT(0), .OPT_CRLF_COLLAPSE(1'b1)) u_max4 (
    .i_clk(i_clk), .i_reset(i_reset), .i_rx_stb(i_rx_stb), .i_rx_data(i_rx_data),
    .o_tx_stb(m_stb), .o_tx_data(m_data), .i_tx_busy(i_tx_busy),
    .o_fill(m_fill), .o_open_len(m_open), .o_overflow(m_ovf));

  line_release_buffer #(.LGFLEN(8), .MAX_LINE(80), .TIMEOUT(100), .OPT_CRLF_COLLAPSE(1'b1)) u_tmo (
    .i_clk(i_clk), .i_reset(i_reset), .i_rx_stb(i_rx_stb), .i_rx_data(i_rx_data),
    .o_tx_stb(t_stb), .o_tx_data(t_data), .i_tx_busy(i_tx_busy),
    .o_fill(t_fill), .o_open_len(t_open), .o_overflow(t_ovf));

  line_release_buffer #(.LGFLEN(4), .MAX_LINE(16), .TIMEOUT(0), .OPT_CRLF_COLLAPSE(1'b1)) u_small (
    .i_clk(i_clk), .i_reset(i_reset), .i_rx_stb(i_rx_stb), .i_rx_data(i_rx_data),
    .o_tx_stb(s_stb), .o_tx_data(s_data), .i_tx_busy(i_tx_busy),
    .o_fill(s_fill), .o_open_len(s_open), .o_overflow(s_ovf));

  // Bytes the transmitter will accept at the coming rising edge.
  always @(negedge i_clk) begin
    if (!i_reset) begin
      if (d_stb && !i_tx_busy) q_d.push_back(d_data);
      if (m_stb && !i_tx_busy) q_m.push_back(m_data);
      if (t_stb && !i_tx_busy) q_t.push_back(t_data);
      if (s_stb && !i_tx_busy) q_s.push_back(s_data);
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    i_rx_data = b;
    i_rx_stb  = 1'b1;
    tick();
    i_rx_stb  = 1'b0;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    tick();
    tick();
    i_reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    tick();
    tick();
    total++; if (d_stb !== 1'b0)  begin bad++; $display("FAIL reset_stb got=%0b want=0", d_stb); end
    total++; if (d_fill !== 9'd0) begin bad++; $display("FAIL reset_fill got=%0d want=0", d_fill); end
    total++; if (d_open !== 9'd0) begin bad++; $display("FAIL reset_open got=%0d want=0", d_open); end
    total++; if (d_ovf !== 1'b0)  begin bad++; $display("FAIL reset_ovf got=%0b want=0", d_ovf); end
    i_reset = 1'b0;
    tick();
    total++; if (s_fill !== 5'd0 || s_stb !== 1'b0) begin bad++; $display("FAIL reset_small got fill=%0d stb=%0b want 0/0", s_fill, s_stb); end
  endtask

  task automatic test_ab_cr();
    int base;
    do_reset();
    i_tx_busy = 1'b0;
    base = q_d.size();
    send(8'h41);
    total++; if (d_fill !== 9'd1 || d_open !== 9'd1) begin bad++; $display("FAIL ab_after_a got fill=%0d open=%0d want 1/1", d_fill, d_open); end
    send(8'h42);
    total++; if (d_stb !== 1'b0) begin bad++; $display("FAIL ab_held got stb=%0b want 0", d_stb); end
    send(8'h0d);
    total++; if (d_stb !== 1'b1 || d_open !== 9'd0 || d_fill !== 9'd3) begin bad++; $display("FAIL ab_release got stb=%0b open=%0d fill=%0d want 1/0/3", d_stb, d_open, d_fill); end
    repeat (3) tick();
    total++; if (d_fill !== 9'd0 || d_stb !== 1'b0) begin bad++; $display("FAIL ab_drain got fill=%0d stb=%0b want 0/0", d_fill, d_stb); end
    total++; if (q_d.size() - base !== 3) begin bad++; $display("FAIL ab_count got=%0d want=3", q_d.size() - base); end
    total++; if (q_d[base] !== 8'h41 || q_d[base+1] !== 8'h42 || q_d[base+2] !== 8'h0d) begin
      bad++; $display("FAIL ab_bytes got=%h %h %h want=41 42 0d", q_d[base], q_d[base+1], q_d[base+2]);
    end
  endtask

  task automatic test_crlf();
    int base;
    do_reset();
    i_tx_busy = 1'b0;
    base = q_d.size();
    send(8'h58);
    send(8'h0d);
    total++; if (d_fill !== 9'd2) begin bad++; $display("FAIL crlf_peak got=%0d want=2", d_fill); end
    send(8'h0a);
    total++; if (d_fill !== 9'd1 || d_ovf !== 1'b0) begin bad++; $display("FAIL crlf_lf_dropped got fill=%0d ovf=%0b want 1/0", d_fill, d_ovf); end
    repeat (3) tick();
    total++; if (d_fill !== 9'd0 || d_open !== 9'd0) begin bad++; $display("FAIL crlf_drain got fill=%0d open=%0d want 0/0", d_fill, d_open); end
    total++; if (q_d.size() - base !== 2) begin bad++; $display("FAIL crlf_count got=%0d want=2", q_d.size() - base); end
    total++; if (q_d[base] !== 8'h58 || q_d[base+1] !== 8'h0d) begin bad++; $display("FAIL crlf_bytes got=%h %h want=58 0d", q_d[base], q_d[base+1]); end
  endtask

  task automatic test_max_line();
    int base;
    do_reset();
    i_tx_busy = 1'b0;
    base = q_m.size();
    send(8'h61);
    send(8'h62);
    send(8'h63);
    total++; if (m_stb !== 1'b0 || m_open !== 9'd3) begin bad++; $display("FAIL max_pre got stb=%0b open=%0d want 0/3", m_stb, m_open); end
    send(8'h64);
    total++; if (m_stb !== 1'b1 || m_open !== 9'd0 || m_fill !== 9'd4) begin bad++; $display("FAIL max_release got stb=%0b open=%0d fill=%0d want 1/0/4", m_stb, m_open, m_fill); end
    send(8'h65);
    send(8'h66);
    repeat (4) tick();
    total++; if (m_open !== 9'd2 || m_fill !== 9'd2 || m_stb !== 1'b0) begin bad++; $display("FAIL max_hold got open=%0d fill=%0d stb=%0b want 2/2/0", m_open, m_fill, m_stb); end
    total++; if (q_m.size() - base !== 4 || q_m[base] !== 8'h61 || q_m[base+3] !== 8'h64) begin
      bad++; $display("FAIL max_first4 got n=%0d first=%h last=%h want 4/61/64", q_m.size() - base, q_m[base], q_m[base+3]);
    end
    send(8'h0a);
    total++; if (m_stb !== 1'b1 || m_open !== 9'd0) begin bad++; $display("FAIL max_term got stb=%0b open=%0d want 1/0", m_stb, m_open); end
    repeat (3) tick();
    total++; if (q_m.size() - base !== 7 || q_m[base+4] !== 8'h65 || q_m[base+5] !== 8'h66 || q_m[base+6] !== 8'h0a || m_fill !== 9'd0) begin
      bad++; $display("FAIL max_tail got n=%0d %h %h %h fill=%0d want 7 65 66 0a 0", q_m.size() - base, q_m[base+4], q_m[base+5], q_m[base+6], m_fill);
    end
  endtask

  task automatic test_timeout();
    int base;
    do_reset();
    i_tx_busy = 1'b0;
    base = q_t.size();
    send(8'h68);
    send(8'h69);
    repeat (99) tick();
    total++; if (t_stb !== 1'b0 || t_open !== 9'd2) begin bad++; $display("FAIL tmo_early got stb=%0b open=%0d want 0/2", t_stb, t_open); end
    tick();
    total++; if (t_stb !== 1'b1 || t_open !== 9'd0) begin bad++; $display("FAIL tmo_fire got stb=%0b open=%0d want 1/0", t_stb, t_open); end
    repeat (3) tick();
    total++; if (q_t.size() - base !== 2 || q_t[base] !== 8'h68 || q_t[base+1] !== 8'h69 || t_fill !== 9'd0) begin
      bad++; $display("FAIL tmo_bytes got n=%0d %h %h fill=%0d want 2 68 69 0", q_t.size() - base, q_t[base], q_t[base+1], t_fill);
    end
    total++; if (d_open !== 9'd2) begin bad++; $display("FAIL tmo_disabled got open=%0d want 2", d_open); end
  endtask

  task automatic test_overflow();
    int base;
    int ovf_cnt;
    int first_ovf;
    do_reset();
    i_tx_busy = 1'b1;
    ovf_cnt   = 0;
    first_ovf = -1;
    for (int i = 0; i < 20; i++) begin
      send(8'(8'h30 + i));
      if (s_ovf === 1'b1) begin
        ovf_cnt++;
        if (first_ovf < 0) first_ovf = i;
      end
    end
    total++; if (ovf_cnt !== 4 || first_ovf !== 16) begin bad++; $display("FAIL ovf_pulses got n=%0d first=%0d want 4/16", ovf_cnt, first_ovf); end
    total++; if (s_fill !== 5'd16 || s_open !== 5'd0 || s_stb !== 1'b1) begin bad++; $display("FAIL ovf_state got fill=%0d open=%0d stb=%0b want 16/0/1", s_fill, s_open, s_stb); end
    base = q_s.size();
    i_tx_busy = 1'b0;
    send(8'h50);
    total++; if (s_fill !== 5'd16 || s_ovf !== 1'b0 || s_open !== 5'd1) begin bad++; $display("FAIL full_rw got fill=%0d ovf=%0b open=%0d want 16/0/1", s_fill, s_ovf, s_open); end
    repeat (16) tick();
    total++; if (s_fill !== 5'd1 || s_stb !== 1'b0) begin bad++; $display("FAIL ovf_drain got fill=%0d stb=%0b want 1/0", s_fill, s_stb); end
    total++; if (q_s.size() - base !== 16) begin bad++; $display("FAIL ovf_count got=%0d want=16", q_s.size() - base); end
    for (int i = 0; i < 16; i++) begin
      total++; if (q_s[base+i] !== 8'(8'h30 + i)) begin bad++; $display("FAIL ovf_byte%0d got=%h want=%h", i, q_s[base+i], 8'(8'h30 + i)); end
    end
  endtask

  task automatic test_reset_mid_tx();
    int base;
    do_reset();
    i_tx_busy = 1'b1;
    send(8'h50); send(8'h0a);
    send(8'h51); send(8'h0a);
    send(8'h52); send(8'h0a);
    total++; if (d_fill !== 9'd6 || d_stb !== 1'b1) begin bad++; $display("FAIL backlog got fill=%0d stb=%0b want 6/1", d_fill, d_stb); end
    i_tx_busy = 1'b0;
    tick();
    tick();
    total++; if (d_fill !== 9'd4) begin bad++; $display("FAIL midtx_fill got=%0d want=4", d_fill); end
    #2;
    i_reset = 1'b1;
    #1;
    total++; if (d_stb !== 1'b0 || d_fill !== 9'd0 || d_open !== 9'd0) begin
      bad++; $display("FAIL async_reset got stb=%0b fill=%0d open=%0d want 0/0/0", d_stb, d_fill, d_open);
    end
    tick();
    i_reset = 1'b0;
    tick();
    base = q_d.size();
    send(8'h5a);
    send(8'h0a);
    repeat (4) tick();
    total++; if (q_d.size() - base !== 2 || q_d[base] !== 8'h5a || q_d[base+1] !== 8'h0a || d_fill !== 9'd0) begin
      bad++; $display("FAIL post_reset got n=%0d %h %h fill=%0d want 2 5a 0a 0", q_d.size() - base, q_d[base], q_d[base+1], d_fill);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    int hi_cnt;
    do_reset();
    i_tx_busy = 1'b0;
    base   = q_d.size();
    hi_cnt = 0;
    send(8'h61);
    send(8'h62);
    send(8'h0a);
    if (d_stb === 1'b1) hi_cnt++;
    send(8'h63);
    if (d_stb === 1'b1) hi_cnt++;
    send(8'h0a);
    if (d_stb === 1'b1) hi_cnt++;
    total++; if (d_fill !== 9'd3 || d_open !== 9'd0) begin bad++; $display("FAIL b2b_merge got fill=%0d open=%0d want 3/0", d_fill, d_open); end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (d_stb === 1'b1) hi_cnt++;
    end
    total++; if (hi_cnt !== 5 || d_fill !== 9'd0) begin bad++; $display("FAIL b2b_stream got hi=%0d fill=%0d want 5/0", hi_cnt, d_fill); end
    total++; if (q_d.size() - base !== 5 || q_d[base+2] !== 8'h0a || q_d[base+3] !== 8'h63 || q_d[base+4] !== 8'h0a) begin
      bad++; $display("FAIL b2b_bytes got n=%0d %h %h %h want 5 0a 63 0a", q_d.size() - base, q_d[base+2], q_d[base+3], q_d[base+4]);
    end
  endtask

  initial begin
    i_reset   = 1'b1;
    i_rx_stb  = 1'b0;
    i_rx_data = 8'h00;
    i_tx_busy = 1'b0;
    test_reset();
    test_ab_cr();
    test_crlf();
    test_max_line();
    test_timeout();
    test_overflow();
    test_reset_mid_tx();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
